// File: rtl/afifo_rd_serializer.sv
// Read-domain consumer for the dual-clock FIFO: pops W-bit words and streams them
// out least-significant slice first as OW-bit slices on a valid/ready channel.
module afifo_rd_serializer #(
  parameter int unsigned W       = 32,
  parameter int unsigned OW      = 8,
  parameter bit          RD_FAST = 1'b1
) (
  input  logic          rd_clk,
  input  logic          rd_reset,
  input  logic          fifo_empty,
  input  logic [W-1:0]  fifo_rd_data,
  output logic          fifo_rd_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  input  logic          flush,
  output logic          busy
);
  localparam int unsigned   N        = W / OW;
  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  word_q;
  logic [CW-1:0] cnt;
  logic          hs;
  logic          done;
  logic          load;

  // State register
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a pop on the final handshake chains straight into the next word
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fifo_rd_en) state_nxt = RD_FAST ? SHIFT : WAIT;
        WAIT:    state_nxt = SHIFT;
        SHIFT:   if (done) state_nxt = fifo_rd_en ? (RD_FAST ? SHIFT : WAIT) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs and handshake decode
  always_comb begin
    out_valid  = (state == SHIFT);
    out_last   = out_valid && (cnt == LAST_CNT);
    out_data   = word_q[32'(cnt) * OW +: OW];
    busy       = (state != IDLE);
    hs         = out_valid && out_ready;
    done       = hs && out_last;
    fifo_rd_en = !rd_reset && !flush && !fifo_empty && ((state == IDLE) || done);
    // Registered-read FIFOs deliver the word one cycle later, in WAIT
    load       = (state == WAIT) || (RD_FAST && fifo_rd_en);
  end

  // Word holding register and slice counter
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (flush) begin
      cnt    <= '0;
    end else if (load) begin
      word_q <= fifo_rd_data;
      cnt    <= '0;
    end else if (hs && !out_last) begin
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_afifo_rd_serializer.sv
// Directed bench for afifo_rd_serializer: one fall-through and one registered-read
// instance, each fed by a small queue-based FIFO model.
module tb_afifo_rd_serializer;
  localparam int unsigned W  = 32;
  localparam int unsigned OW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rd_reset;
  logic          f_empty, f_rd_en, f_valid, f_ready, f_last, f_flush, f_busy;
  logic [W-1:0]  f_rd_data;
  logic [OW-1:0] f_data;
  logic          s_empty, s_rd_en, s_valid, s_ready, s_last, s_flush, s_busy;
  logic [W-1:0]  s_rd_data;
  logic [OW-1:0] s_data;

  logic [W-1:0] fq[$];
  logic [W-1:0] sq[$];
  logic         force_empty_f;
  int           n_chk;
  int           n_pass;

  afifo_rd_serializer #(.W(W), .OW(OW), .RD_FAST(1'b1)) u_fast (
    .rd_clk(clk), .rd_reset(rd_reset), .fifo_empty(f_empty), .fifo_rd_data(f_rd_data),
    .fifo_rd_en(f_rd_en), .out_valid(f_valid), .out_ready(f_ready), .out_data(f_data),
    .out_last(f_last), .flush(f_flush), .busy(f_busy)
  );

  afifo_rd_serializer #(.W(W), .OW(OW), .RD_FAST(1'b0)) u_slow (
    .rd_clk(clk), .rd_reset(rd_reset), .fifo_empty(s_empty), .fifo_rd_data(s_rd_data),
    .fifo_rd_en(s_rd_en), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_last(s_last), .flush(s_flush), .busy(s_busy)
  );

  function automatic void refresh();
    f_empty   = force_empty_f || (fq.size() == 0);
    f_rd_data = (fq.size() > 0) ? fq[0] : '0;
    s_empty   = (sq.size() == 0);
  endfunction

  // Advance one cycle: sample pops mid-cycle, update FIFO models just after the edge
  task automatic next();
    logic         pf, ps;
    logic [W-1:0] d;
    @(negedge clk);
    pf = f_rd_en;
    ps = s_rd_en;
    @(posedge clk);
    #1;
    if (pf && fq.size() > 0) d = fq.pop_front();
    if (ps && sq.size() > 0) s_rd_data = sq.pop_front();
    refresh();
    #1;
  endtask

  task automatic test_reset();
    rd_reset = 1'b1;
    next();
    next();
    n_chk++; if (f_valid !== 1'b0) $display("FAIL rst_f_valid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_data !== 8'h00) $display("FAIL rst_f_data got %h exp 00", f_data); else n_pass++;
    n_chk++; if (f_last !== 1'b0) $display("FAIL rst_f_last got %b exp 0", f_last); else n_pass++;
    n_chk++; if (f_busy !== 1'b0) $display("FAIL rst_f_busy got %b exp 0", f_busy); else n_pass++;
    n_chk++; if (f_rd_en !== 1'b0) $display("FAIL rst_f_rd_en got %b exp 0", f_rd_en); else n_pass++;
    n_chk++; if (s_valid !== 1'b0) $display("FAIL rst_s_valid got %b exp 0", s_valid); else n_pass++;
    n_chk++; if (s_busy !== 1'b0) $display("FAIL rst_s_busy got %b exp 0", s_busy); else n_pass++;
    rd_reset = 1'b0;
    next();
    n_chk++; if (f_valid !== 1'b0) $display("FAIL post_rst_f_valid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_rd_en !== 1'b0) $display("FAIL post_rst_f_rd_en got %b exp 0", f_rd_en); else n_pass++;
    n_chk++; if (s_busy !== 1'b0) $display("FAIL post_rst_s_busy got %b exp 0", s_busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    f_ready = 1'b1;
    fq.push_back(32'hDDCCBBAA);
    refresh();
    #1;
    n_chk++; if (f_rd_en !== 1'b1) $display("FAIL single_pop got %b exp 1", f_rd_en); else n_pass++;
    next();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (f_valid !== 1'b1) $display("FAIL single_valid[%0d] got %b exp 1", i, f_valid); else n_pass++;
      n_chk++; if (f_data !== exp_b[i]) $display("FAIL single_data[%0d] got %h exp %h", i, f_data, exp_b[i]); else n_pass++;
      n_chk++; if (f_last !== ((i == 3) ? 1'b1 : 1'b0)) $display("FAIL single_last[%0d] got %b", i, f_last); else n_pass++;
      n_chk++; if (f_busy !== 1'b1) $display("FAIL single_busy[%0d] got %b exp 1", i, f_busy); else n_pass++;
      n_chk++; if (f_rd_en !== 1'b0) $display("FAIL single_no_pop[%0d] got %b exp 0", i, f_rd_en); else n_pass++;
      next();
    end
    n_chk++; if (f_valid !== 1'b0) $display("FAIL single_end_valid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_busy !== 1'b0) $display("FAIL single_end_busy got %b exp 0", f_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    f_ready = 1'b1;
    fq.push_back(32'h04030201);
    fq.push_back(32'h08070605);
    refresh();
    #1;
    n_chk++; if (f_rd_en !== 1'b1) $display("FAIL b2b_pop0 got %b exp 1", f_rd_en); else n_pass++;
    next();
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (f_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b exp 1", i, f_valid); else n_pass++;
      n_chk++; if (f_data !== 8'(i + 1)) $display("FAIL b2b_data[%0d] got %h exp %h", i, f_data, 8'(i + 1)); else n_pass++;
      n_chk++; if (f_last !== ((i % 4 == 3) ? 1'b1 : 1'b0)) $display("FAIL b2b_last[%0d] got %b", i, f_last); else n_pass++;
      n_chk++; if (f_rd_en !== ((i == 3) ? 1'b1 : 1'b0)) $display("FAIL b2b_rd_en[%0d] got %b", i, f_rd_en); else n_pass++;
      next();
    end
    n_chk++; if (f_busy !== 1'b0) $display("FAIL b2b_end_busy got %b exp 0", f_busy); else n_pass++;
  endtask

  task automatic test_slow();
    s_ready = 1'b1;
    sq.push_back(32'h04030201);
    sq.push_back(32'h08070605);
    refresh();
    #1;
    n_chk++; if (s_rd_en !== 1'b1) $display("FAIL slow_pop0 got %b exp 1", s_rd_en); else n_pass++;
    for (int w = 0; w < 2; w++) begin
      next();
      n_chk++; if (s_valid !== 1'b0) $display("FAIL slow_bubble_valid[%0d] got %b exp 0", w, s_valid); else n_pass++;
      n_chk++; if (s_busy !== 1'b1) $display("FAIL slow_bubble_busy[%0d] got %b exp 1", w, s_busy); else n_pass++;
      n_chk++; if (s_rd_en !== 1'b0) $display("FAIL slow_wait_pop[%0d] got %b exp 0", w, s_rd_en); else n_pass++;
      next();
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (s_valid !== 1'b1) $display("FAIL slow_valid[%0d] got %b exp 1", w * 4 + i, s_valid); else n_pass++;
        n_chk++; if (s_data !== 8'(w * 4 + i + 1)) $display("FAIL slow_data[%0d] got %h exp %h", w * 4 + i, s_data, 8'(w * 4 + i + 1)); else n_pass++;
        n_chk++; if (s_last !== ((i == 3) ? 1'b1 : 1'b0)) $display("FAIL slow_last[%0d] got %b", w * 4 + i, s_last); else n_pass++;
        n_chk++; if (s_rd_en !== ((i == 3 && w == 0) ? 1'b1 : 1'b0)) $display("FAIL slow_rd_en[%0d] got %b", w * 4 + i, s_rd_en); else n_pass++;
        if (i < 3) next();
      end
    end
    next();
    n_chk++; if (s_busy !== 1'b0) $display("FAIL slow_end_busy got %b exp 0", s_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [7] = '{8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    f_ready = 1'b1;
    fq.push_back(32'hDDCCBBAA);
    refresh();
    #1;
    next();
    n_chk++; if (f_data !== 8'hAA) $display("FAIL bp_first got %h exp aa", f_data); else n_pass++;
    next();
    fq.push_back(32'h44332211);
    refresh();
    f_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (f_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, f_valid); else n_pass++;
      n_chk++; if (f_data !== 8'hBB) $display("FAIL bp_data[%0d] got %h exp bb", i, f_data); else n_pass++;
      n_chk++; if (f_last !== 1'b0) $display("FAIL bp_last[%0d] got %b exp 0", i, f_last); else n_pass++;
      n_chk++; if (f_rd_en !== 1'b0) $display("FAIL bp_no_pop[%0d] got %b exp 0", i, f_rd_en); else n_pass++;
      n_chk++; if (u_fast.cnt !== 2'd1) $display("FAIL bp_cnt[%0d] got %0d exp 1", i, u_fast.cnt); else n_pass++;
      next();
    end
    f_ready = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      n_chk++; if (f_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d] got %b exp 1", k, f_valid); else n_pass++;
      n_chk++; if (f_data !== exp_b[k]) $display("FAIL bp_drain_data[%0d] got %h exp %h", k, f_data, exp_b[k]); else n_pass++;
      n_chk++; if (f_rd_en !== ((k == 2) ? 1'b1 : 1'b0)) $display("FAIL bp_drain_rd_en[%0d] got %b", k, f_rd_en); else n_pass++;
      next();
    end
    n_chk++; if (f_busy !== 1'b0) $display("FAIL bp_end_busy got %b exp 0", f_busy); else n_pass++;
  endtask

  task automatic test_flush();
    logic [7:0] exp_b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    f_ready = 1'b1;
    fq.push_back(32'hDDCCBBAA);
    refresh();
    #1;
    next();
    next();
    n_chk++; if (f_data !== 8'hBB) $display("FAIL flush_pre_data got %h exp bb", f_data); else n_pass++;
    fq.push_back(32'h88776655);
    refresh();
    f_flush = 1'b1;
    #1;
    n_chk++; if (f_rd_en !== 1'b0) $display("FAIL flush_no_pop got %b exp 0", f_rd_en); else n_pass++;
    next();
    f_flush = 1'b0;
    #1;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", f_busy); else n_pass++;
    n_chk++; if (f_rd_en !== 1'b1) $display("FAIL flush_repop got %b exp 1", f_rd_en); else n_pass++;
    next();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (f_data !== exp_b[i]) $display("FAIL flush_next_data[%0d] got %h exp %h", i, f_data, exp_b[i]); else n_pass++;
      n_chk++; if (f_last !== ((i == 3) ? 1'b1 : 1'b0)) $display("FAIL flush_next_last[%0d] got %b", i, f_last); else n_pass++;
      next();
    end
    n_chk++; if (f_busy !== 1'b0) $display("FAIL flush_end_busy got %b exp 0", f_busy); else n_pass++;
  endtask

  task automatic test_flush_wait();
    s_ready = 1'b1;
    sq.push_back(32'h13121110);
    sq.push_back(32'h23222120);
    refresh();
    #1;
    n_chk++; if (s_rd_en !== 1'b1) $display("FAIL fw_pop got %b exp 1", s_rd_en); else n_pass++;
    next();
    s_flush = 1'b1;
    #1;
    n_chk++; if (s_rd_en !== 1'b0) $display("FAIL fw_no_pop got %b exp 0", s_rd_en); else n_pass++;
    n_chk++; if (s_busy !== 1'b1) $display("FAIL fw_wait_busy got %b exp 1", s_busy); else n_pass++;
    next();
    s_flush = 1'b0;
    #1;
    n_chk++; if (s_busy !== 1'b0) $display("FAIL fw_idle_busy got %b exp 0", s_busy); else n_pass++;
    n_chk++; if (s_rd_en !== 1'b1) $display("FAIL fw_repop got %b exp 1", s_rd_en); else n_pass++;
    next();
    n_chk++; if (s_valid !== 1'b0) $display("FAIL fw_wait2_valid got %b exp 0", s_valid); else n_pass++;
    next();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (s_data !== 8'(8'h20 + i)) $display("FAIL fw_data[%0d] got %h exp %h", i, s_data, 8'(8'h20 + i)); else n_pass++;
      next();
    end
    n_chk++; if (s_busy !== 1'b0) $display("FAIL fw_end_busy got %b exp 0", s_busy); else n_pass++;
  endtask

  task automatic test_empty_reset();
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    f_ready = 1'b1;
    force_empty_f = 1'b1;
    fq.push_back(32'hDDCCBBAA);
    fq.push_back(32'h44332211);
    refresh();
    #1;
    for (int i = 0; i < 20; i++) begin
      n_chk++; if (f_rd_en !== 1'b0) $display("FAIL empty_no_pop[%0d] got %b exp 0", i, f_rd_en); else n_pass++;
      next();
    end
    force_empty_f = 1'b0;
    refresh();
    #1;
    n_chk++; if (f_rd_en !== 1'b1) $display("FAIL empty_release_pop got %b exp 1", f_rd_en); else n_pass++;
    next();
    next();
    next();
    next();
    n_chk++; if (f_last !== 1'b1) $display("FAIL rst_mid_last got %b exp 1", f_last); else n_pass++;
    rd_reset = 1'b1;
    #1;
    n_chk++; if (f_rd_en !== 1'b0) $display("FAIL rst_gates_pop got %b exp 0", f_rd_en); else n_pass++;
    next();
    n_chk++; if (f_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", f_busy); else n_pass++;
    n_chk++; if (f_data !== 8'h00) $display("FAIL rst_mid_data got %h exp 00", f_data); else n_pass++;
    force_empty_f = 1'b1;
    refresh();
    rd_reset = 1'b0;
    #1;
    n_chk++; if (f_rd_en !== 1'b0) $display("FAIL rst_exit_no_pop got %b exp 0", f_rd_en); else n_pass++;
    next();
    force_empty_f = 1'b0;
    refresh();
    #1;
    n_chk++; if (f_rd_en !== 1'b1) $display("FAIL rst_exit_pop got %b exp 1", f_rd_en); else n_pass++;
    next();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (f_data !== exp_b[i]) $display("FAIL rst_next_data[%0d] got %h exp %h", i, f_data, exp_b[i]); else n_pass++;
      next();
    end
    n_chk++; if (f_busy !== 1'b0) $display("FAIL rst_end_busy got %b exp 0", f_busy); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rd_reset = 1'b1;
    force_empty_f = 1'b0;
    f_ready = 1'b1;
    s_ready = 1'b1;
    f_flush = 1'b0;
    s_flush = 1'b0;
    s_rd_data = '0;
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_slow();
    test_backpressure();
    test_flush();
    test_flush_wait();
    test_empty_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
